div3_serial_engine: RTL and testbench
=====================================

Name: div3_serial_engine

Overview:
- Sequential, bit-serial divide-by-3 unit. Accepts a WIDTH-bit dividend and a 2-bit incoming remainder over a valid/ready handshake.
- Produces the WIDTH-bit quotient and 2-bit remainder after WIDTH clocks, one dividend bit per cycle, MSB first.
- Sits alongside the combinational divide-by-3 array. It is the area-reduced, cycle-based equivalent that feeds downstream consumers over a handshake.
- Chaining: its remainder output can drive the next word's remainder input, so it can also divide multi-word operands.

Parameters:
WIDTH, 8, dividend/quotient width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, asynchronous assert, active-low
in_valid  input  1  dividend and remainder-in are valid
in_ready  output  1  engine can accept an operand
in_data  input  WIDTH  dividend word, MSB processed first
in_rem  input  2  incoming remainder (0..2), i.e. high-order residue
out_valid  output  1  quot/rem valid
out_ready  input  1  consumer accepts result
quot  output  WIDTH  quotient of (in_rem*2^WIDTH + in_data)/3
rem  output  2  remainder of same, 0..2
busy  output  1  high while in BUSY state

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low, ports named clk and rst_n. While rst_n=0 the block is held in reset.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - quot=0, rem=0, internal shift register=0, bit counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, load in_data into the shift register and in_rem into the remainder register, clear the counter, and go to BUSY.
  - in_rem=3 is illegal and is loaded as 0.
  - BUSY: in_ready=0, busy=1. Each cycle, take bit x = shift_reg MSB and current remainder r, then:
    - quotient bit q = (r==2) | (r==1 & x).
    - next r' = (2r + x) mod 3. Encodings: 0→00, 1→01, 2→10.
    - Shift the register left one place and insert q at the LSB. The register holds the quotient once all bits are processed.
    - Counter increments each cycle. The transition is taken on the edge that processes bit index 0 (counter==WIDTH-1), and goes to DONE.
  - DONE: out_valid=1, quot=shift register, rem=remainder register. These hold stable until out_valid&out_ready. On that edge go to IDLE and drop out_valid.
- Latency and throughput:
  - Operand accepted on edge A. out_valid rises after edge A+WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles.
  - in_ready is high only in IDLE; there is no overlap of operands.
- Output register contents:
  - quot/rem outside DONE: registers keep their last result. Consumers qualify with out_valid only.
  - Remainder register never holds 3 in any state.
- Range: the quotient always fits in WIDTH bits because in_rem<=2.
- Reset mid-operation: an asynchronous drop of rst_n in any state forces the reset values immediately. The in-flight operand is discarded, with no partial result and no out_valid.
- Simultaneous events:
  - in_valid asserted in BUSY/DONE is ignored (in_ready=0). The upstream holds the operand.
  - out_ready while not out_valid has no effect.

Test Plan:
- Basic divide: WIDTH=8, in_rem=0, in_data=100 → after 8 cycles out_valid=1, quot=33, rem=1.
- Boundary values:
  - in_data=255, in_rem=0 → quot=85, rem=0.
  - in_data=0, in_rem=0 → quot=0, rem=0.
- Incoming remainder and chaining:
  - in_rem=2, in_data=0x00 → quot=170, rem=2 (512/3).
  - Chain two words 0x01,0x00 (value 256), feeding rem→in_rem → quot words 0x00,0x55, final rem=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → quot/rem/out_valid stable and in_ready=0 throughout. The edge with out_ready=1 returns to IDLE, and in_ready=1 on the next cycle.
- Reset mid-operation: assert rst_n=0 at bit 4 of in_data=200 → out_valid=0, busy=0, in_ready=1 immediately. A new operand 9 then yields quot=3, rem=0.
- Exhaustive check: WIDTH=8, all in_data 0..255 × in_rem 0..3 (3 treated as 0) → compare against an arithmetic model. Latency is exactly 8 cycles from acceptance to out_valid.

Source files
------------

// File: rtl/div3_serial_engine.sv
// Bit-serial divide-by-3 engine.
// Takes a WIDTH-bit dividend plus a 2-bit high-order residue and divides
// (in_rem*2^WIDTH + in_data) by 3, one bit per clock, MSB first.
// The quotient builds up in place in the shift register. The remainder output
// can be fed back into in_rem so that multi-word operands divide word by word.
module div3_serial_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_rem,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [1:0]       rem,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [1:0]       rreg;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             release_out;
  logic             last_bit;
  logic             x;
  logic             q_bit;
  logic [1:0]       r_nxt;
  logic [1:0]       rem_load;
  logic [WIDTH-1:0] sreg_nxt;

  assign accept      = (state == IDLE) && in_valid;
  assign release_out = (state == DONE) && out_ready;
  assign last_bit    = (state == BUSY) && (cnt == LAST);

  // Residue illegal value 3 is folded to 0 so the remainder never holds 3.
  assign rem_load = (in_rem == 2'd3) ? 2'd0 : in_rem;

  // One restoring step of division by 3: combine the residue with the next dividend bit.
  always_comb begin
    x     = sreg[WIDTH-1];
    q_bit = rreg[1] | (rreg[0] & x);
    r_nxt = 2'd0;
    unique case ({rreg, x})
      3'b00_0: r_nxt = 2'd0;
      3'b00_1: r_nxt = 2'd1;
      3'b01_0: r_nxt = 2'd2;
      3'b01_1: r_nxt = 2'd0;
      3'b10_0: r_nxt = 2'd1;
      3'b10_1: r_nxt = 2'd2;
      default: r_nxt = 2'd0;
    endcase
    sreg_nxt = {sreg[WIDTH-2:0], q_bit};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)      state_nxt = BUSY;
      BUSY:    if (last_bit)    state_nxt = DONE;
      DONE:    if (release_out) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // FSM outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE:    in_ready  = 1'b1;
      BUSY:    busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: load on accept, one quotient bit per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      rreg <= 2'd0;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= in_data;
      rreg <= rem_load;
      cnt  <= '0;
    end else if (state == BUSY) begin
      sreg <= sreg_nxt;
      rreg <= r_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  // Result registers capture on the final bit and hold until the next result,
  // so quot/rem stay stable through backpressure and between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot <= '0;
      rem  <= 2'd0;
    end else if (last_bit) begin
      quot <= sreg_nxt;
      rem  <= r_nxt;
    end
  end

endmodule

// File: tb/tb_div3_serial_engine.sv
// Directed bench for div3_serial_engine (WIDTH=8).
module tb_div3_serial_engine;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [1:0]   in_rem;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quot;
  logic [1:0]   rem;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  div3_serial_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rem    (in_rem),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Present one operand, wait for the result, check latency/quot/rem, then pop it.
  task automatic do_op(input string tag, input logic [W-1:0] d, input logic [1:0] r,
                       input int exp_q, input int exp_r);
    int lat;
    in_data  = d;
    in_rem   = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"},  lat, W);
    chk({tag, "_quot"}, int'(quot), exp_q);
    chk({tag, "_rem"},  int'(rem), exp_r);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [1:0] chain_r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_rem    = 2'd0;
    out_ready = 1'b0;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready",  int'(in_ready),  1);
    chk("rst_busy",      int'(busy),      0);
    chk("rst_quot",      int'(quot),      0);
    chk("rst_rem",       int'(rem),       0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and boundary values.
    do_op("d100", 8'd100, 2'd0, 33, 1);
    do_op("d255", 8'd255, 2'd0, 85, 0);
    do_op("d0",   8'd0,   2'd0, 0,  0);
    do_op("r2d0", 8'd0,   2'd2, 170, 2);
    do_op("r3d9", 8'd9,   2'd3, 3,  0);

    // Chain 0x01,0x00 = 256: remainder of first word feeds the second.
    do_op("ch0", 8'h01, 2'd0, 0, 1);
    chain_r = rem;
    do_op("ch1", 8'h00, chain_r, 8'h55, 1);

    // Backpressure: hold result 5 cycles while a new operand is offered.
    in_data  = 8'd100;
    in_rem   = 2'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_data = 8'd7;
    chk("bp_busy", int'(busy), 1);
    chk("bp_in_ready_busy", int'(in_ready), 0);
    repeat (W) begin @(posedge clk); #1; end
    chk("bp_valid0", int'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_quot",  int'(quot),      33);
      chk("bp_hold_rem",   int'(rem),       1);
      chk("bp_hold_ready", int'(in_ready),  0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_rel_valid", int'(out_valid), 0);
    chk("bp_rel_ready", int'(in_ready),  1);
    chk("bp_keep_quot", int'(quot),      33);
    // out_ready while idle does nothing.
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_ordy_valid", int'(out_valid), 0);
    chk("idle_ordy_ready", int'(in_ready),  1);

    // Reset mid-operation on 200.
    in_data  = 8'd200;
    in_rem   = 2'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", int'(out_valid), 0);
    chk("mid_busy",      int'(busy),      0);
    chk("mid_in_ready",  int'(in_ready),  1);
    chk("mid_quot",      int'(quot),      0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_no_valid", int'(out_valid), 0);
    do_op("post_rst_d9", 8'd9, 2'd0, 3, 0);

    // Exhaustive sweep against arithmetic model.
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 256; d++) begin
        int v;
        v = ((r == 3) ? 0 : r) * 256 + d;
        do_op("sweep", W'(d), 2'(r), v / 3, v % 3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
